// File: rtl/pc_fetch_ctrl.sv
// PC register and instruction-fetch controller: imem request/ack on one side, decode valid/ready on the other.
// Optional FETCH_PERF_EN builds the fetch and redirect counters; without it both counter ports read 0.
module pc_fetch_ctrl #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  output logic            imem_req_o,
  output logic [PC_W-1:0] imem_addr_o,
  input  logic            imem_ack_i,
  input  logic [31:0]     imem_data_i,
  output logic            instr_valid_o,
  output logic [31:0]     instr_o,
  output logic [PC_W-1:0] instr_pc_o,
  input  logic            instr_ready_i,
  input  logic            branch_i,
  input  logic [PC_W-1:0] branch_pc_i,
  input  logic [PC_W-1:0] branch_off_i,
  input  logic            jump_i,
  input  logic [PC_W-1:0] jump_tgt_i,
  output logic [31:0]     fetch_cnt_o,
  output logic [31:0]     redirect_cnt_o
);

  // state  | meaning
  // S_IDLE | after reset, no request; loads the first fetch address
  // S_REQ  | request outstanding, waiting for imem_ack_i (may be draining)
  // S_HOLD | instruction buffered, offered to decode
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] fetch_addr_q, fetch_addr_d;
  logic [PC_W-1:0] instr_pc_q, instr_pc_d;
  logic [31:0]     instr_q, instr_d;
  logic            drain_q, drain_d;
  logic            redirect;
  logic [PC_W-1:0] branch_tgt, redirect_tgt;

  assign branch_tgt   = branch_pc_i + PC_W'(4) + branch_off_i;
  assign redirect     = branch_i | jump_i;
  assign redirect_tgt = branch_i ? branch_tgt : jump_tgt_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      fetch_addr_q <= RESET_PC;
      instr_pc_q   <= '0;
      instr_q      <= '0;
      drain_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fetch_addr_q <= fetch_addr_d;
      instr_pc_q   <= instr_pc_d;
      instr_q      <= instr_d;
      drain_q      <= drain_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fetch_addr_d = fetch_addr_q;
    instr_pc_d   = instr_pc_q;
    instr_d      = instr_q;
    drain_d      = drain_q;
    if (redirect) pc_d = redirect_tgt;
    case (state_q)
      S_IDLE: begin
        state_d      = S_REQ;
        fetch_addr_d = redirect ? redirect_tgt : pc_q;
      end
      S_REQ: begin
        if (imem_ack_i) begin
          if (redirect) begin
            fetch_addr_d = redirect_tgt;
            drain_d      = 1'b0;
          end else if (drain_q) begin
            drain_d      = 1'b0;
            fetch_addr_d = pc_q;
          end else begin
            instr_d    = imem_data_i;
            instr_pc_d = fetch_addr_q;
            pc_d       = fetch_addr_q + PC_W'(4);
            state_d    = S_HOLD;
          end
        end else if (redirect) begin
          // address must stay stable; the returning data is thrown away
          drain_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          fetch_addr_d = redirect_tgt;
          state_d      = S_REQ;
        end else if (instr_ready_i) begin
          fetch_addr_d = pc_q;
          state_d      = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign imem_req_o    = (state_q == S_REQ);
  assign imem_addr_o   = fetch_addr_q;
  assign instr_valid_o = (state_q == S_HOLD);
  assign instr_o       = instr_q;
  assign instr_pc_o    = instr_pc_q;

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, redirect_cnt_q;
  logic        fetch_done;

  assign fetch_done = (state_q == S_HOLD) & instr_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_cnt_q    <= '0;
      redirect_cnt_q <= '0;
    end else begin
      if (fetch_done) fetch_cnt_q    <= fetch_cnt_q + 32'd1;
      if (redirect)   redirect_cnt_q <= redirect_cnt_q + 32'd1;
    end
  end

  assign fetch_cnt_o    = fetch_cnt_q;
  assign redirect_cnt_o = redirect_cnt_q;
`else
  assign fetch_cnt_o    = '0;
  assign redirect_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: redirect-target vector table plus hand-written multi-cycle sequences.
module tb_pc_fetch_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_data_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i;
  logic        branch_i;
  logic [31:0] branch_pc_i;
  logic [31:0] branch_off_i;
  logic        jump_i;
  logic [31:0] jump_tgt_i;
  logic [31:0] fetch_cnt_o;
  logic [31:0] redirect_cnt_o;

  pc_fetch_ctrl #(.PC_W(32), .RESET_PC(32'h100)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .imem_req_o     (imem_req_o),
    .imem_addr_o    (imem_addr_o),
    .imem_ack_i     (imem_ack_i),
    .imem_data_i    (imem_data_i),
    .instr_valid_o  (instr_valid_o),
    .instr_o        (instr_o),
    .instr_pc_o     (instr_pc_o),
    .instr_ready_i  (instr_ready_i),
    .branch_i       (branch_i),
    .branch_pc_i    (branch_pc_i),
    .branch_off_i   (branch_off_i),
    .jump_i         (jump_i),
    .jump_tgt_i     (jump_tgt_i),
    .fetch_cnt_o    (fetch_cnt_o),
    .redirect_cnt_o (redirect_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        branch;
    logic [31:0] bpc;
    logic [31:0] boff;
    logic        jump;
    logic [31:0] jtgt;
    logic        ready;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs[6];
  int   checks = 0;
  int   errors = 0;
  int   mem_cnt = 0;
  int   mem_lat = 0;
  bit   mem_auto = 1'b1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // memory answers after mem_lat unacknowledged request cycles
  task automatic tick();
    logic ack_prev, req_prev;
    ack_prev = imem_ack_i;
    req_prev = imem_req_o;
    @(posedge clk_i);
    #1;
    if (ack_prev || !req_prev) mem_cnt = 0;
    else mem_cnt++;
    if (mem_auto) begin
      imem_ack_i  = imem_req_o && (mem_cnt >= mem_lat);
      imem_data_i = mem_word(imem_addr_o);
    end
  endtask

  initial begin
    vecs[0] = '{1'b1, 32'h0000_0200, 32'hFFFF_FFF0, 1'b0, 32'h0,       1'b0, 32'h0000_01F4};
    vecs[1] = '{1'b1, 32'h0000_1000, 32'h0000_0040, 1'b0, 32'h0,       1'b0, 32'h0000_1044};
    vecs[2] = '{1'b0, 32'h0,         32'h0,         1'b1, 32'h400,     1'b0, 32'h0000_0400};
    vecs[3] = '{1'b1, 32'h0000_0300, 32'h0000_0008, 1'b1, 32'h800,     1'b0, 32'h0000_030C};
    vecs[4] = '{1'b1, 32'hFFFF_FFF8, 32'h0000_0008, 1'b0, 32'h0,       1'b0, 32'h0000_0004};
    vecs[5] = '{1'b1, 32'h0000_0040, 32'h0000_0000, 1'b0, 32'h0,       1'b1, 32'h0000_0044};

    rst_i = 1'b1; imem_ack_i = 1'b0; imem_data_i = '0; instr_ready_i = 1'b0;
    branch_i = 1'b0; branch_pc_i = '0; branch_off_i = '0; jump_i = 1'b0; jump_tgt_i = '0;
    tick(); tick();
    check("rst_req", {31'd0, imem_req_o}, 32'd0);
    check("rst_valid", {31'd0, instr_valid_o}, 32'd0);
    check("rst_instr", instr_o, 32'd0);
    check("rst_instr_pc", instr_pc_o, 32'd0);
    check("rst_addr", imem_addr_o, 32'h100);
    check("rst_fetch_cnt", fetch_cnt_o, 32'd0);
    check("rst_redir_cnt", redirect_cnt_o, 32'd0);

    // zero-wait streaming with ready held high
    rst_i = 1'b0; instr_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stream_req", {31'd0, imem_req_o}, 32'd1);
      check("stream_addr", imem_addr_o, 32'h100 + 32'(4 * k));
      check("stream_valid_lo", {31'd0, instr_valid_o}, 32'd0);
      if (k == 2) instr_ready_i = 1'b0;
      tick();
      check("stream_valid_hi", {31'd0, instr_valid_o}, 32'd1);
      check("stream_req_lo", {31'd0, imem_req_o}, 32'd0);
      check("stream_pc", instr_pc_o, 32'h100 + 32'(4 * k));
      check("stream_data", instr_o, mem_word(32'h100 + 32'(4 * k)));
    end

    // redirect from HOLD: target formation and buffer drop
    for (int v = 0; v < 6; v++) begin
      for (int w = 0; w < 20 && !instr_valid_o; w++) tick();
      check("tbl_in_hold", {31'd0, instr_valid_o}, 32'd1);
      branch_i = vecs[v].branch; branch_pc_i = vecs[v].bpc; branch_off_i = vecs[v].boff;
      jump_i = vecs[v].jump; jump_tgt_i = vecs[v].jtgt; instr_ready_i = vecs[v].ready;
      tick();
      branch_i = 1'b0; jump_i = 1'b0; instr_ready_i = 1'b0;
      check("tbl_req", {31'd0, imem_req_o}, 32'd1);
      check("tbl_addr", imem_addr_o, vecs[v].exp_addr);
      check("tbl_valid_drop", {31'd0, instr_valid_o}, 32'd0);
      tick();
      check("tbl_valid", {31'd0, instr_valid_o}, 32'd1);
      check("tbl_instr_pc", instr_pc_o, vecs[v].exp_addr);
      check("tbl_instr", instr_o, mem_word(vecs[v].exp_addr));
    end

    // redirect during a 3-wait-cycle request to 0x10
    mem_lat = 3;
    jump_i = 1'b1; jump_tgt_i = 32'h10;
    tick();
    check("wait_addr0", imem_addr_o, 32'h10);
    jump_tgt_i = 32'h400;
    tick();
    jump_i = 1'b0;
    check("wait_addr1", imem_addr_o, 32'h10);
    check("wait_req1", {31'd0, imem_req_o}, 32'd1);
    tick();
    check("wait_addr2", imem_addr_o, 32'h10);
    tick();
    check("wait_addr3", imem_addr_o, 32'h10);
    check("wait_ack3", {31'd0, imem_ack_i}, 32'd1);
    tick();
    check("drain_addr", imem_addr_o, 32'h400);
    check("drain_req", {31'd0, imem_req_o}, 32'd1);
    check("drain_valid", {31'd0, instr_valid_o}, 32'd0);
    tick(); tick(); tick(); tick();
    check("drain_valid_hi", {31'd0, instr_valid_o}, 32'd1);
    check("drain_instr_pc", instr_pc_o, 32'h400);

    // reset while a request is outstanding, then a stray ack in IDLE
    instr_ready_i = 1'b1;
    tick();
    instr_ready_i = 1'b0;
    check("mid_req", {31'd0, imem_req_o}, 32'd1);
    check("mid_addr", imem_addr_o, 32'h404);
    rst_i = 1'b1;
    tick();
    check("mid_rst_req", {31'd0, imem_req_o}, 32'd0);
    check("mid_rst_valid", {31'd0, instr_valid_o}, 32'd0);
    check("mid_rst_addr", imem_addr_o, 32'h100);
    mem_auto = 1'b0; rst_i = 1'b0;
    imem_ack_i = 1'b1; imem_data_i = 32'hBAD0_BAD0;
    tick();
    check("idle_ack_req", {31'd0, imem_req_o}, 32'd1);
    check("idle_ack_addr", imem_addr_o, 32'h100);
    check("idle_ack_valid", {31'd0, instr_valid_o}, 32'd0);
    imem_data_i = mem_word(32'h100);
    tick();
    check("refetch_valid", {31'd0, instr_valid_o}, 32'd1);
    check("refetch_pc", instr_pc_o, 32'h100);
    check("refetch_instr", instr_o, mem_word(32'h100));
    imem_ack_i = 1'b0; mem_auto = 1'b1; mem_lat = 0;

    // counters: 5 handshakes, 2 redirects after a fresh reset
    rst_i = 1'b1;
    tick(); tick();
    rst_i = 1'b0; instr_ready_i = 1'b1;
    repeat (11) tick();
    instr_ready_i = 1'b0;
    tick();
    jump_i = 1'b1; jump_tgt_i = 32'h400;
    tick();
    jump_i = 1'b0;
    tick();
    branch_i = 1'b1; branch_pc_i = 32'h200; branch_off_i = 32'h0;
    tick();
    branch_i = 1'b0;
`ifdef FETCH_PERF_EN
    check("perf_fetch_cnt", fetch_cnt_o, 32'd5);
    check("perf_redir_cnt", redirect_cnt_o, 32'd2);
`else
    check("perf_fetch_cnt", fetch_cnt_o, 32'd0);
    check("perf_redir_cnt", redirect_cnt_o, 32'd0);
`endif
    check("perf_addr", imem_addr_o, 32'h204);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
